// File: rtl/serial_master_port.sv
// serial_master_port
//   Master-side serial bus engine. Accepts one parallel transaction request at a
//   time, serialises a config frame on 'control', waits for the slave's ready
//   handshake, then either streams write words on wD or deserialises read words
//   from rD. Single-word and burst transfers are supported.
//
// Ports
//   clk, reset        clock (rising edge) and synchronous active-high reset
//   req, req_*        transaction request; sampled only while idle
//   wr_data, wr_pop   write word source; wr_pop pulses the cycle after a word is taken
//   rd_data, rd_valid last received read word and its 1-cycle update strobe
//   busy, done        transaction in progress / 1-cycle end-of-transaction pulse
//   err_timeout       pulses together with done when the ready handshake timed out
//   control           serial config frame, MSB first
//   wD, valid, last   serial write data, per-bit valid, final-word marker
//   rD, ready         serial read data and slave ready line (idles high)
//   state_dbg         current FSM state, for observation only
//
// Handshake: after the frame, the slave signals it is prepared by pulling ready
// low and then releasing it high; only a low-then-high sequence starts the data
// phase (a ready line that never went low is not trusted). During a write, every
// bit on wD is qualified by valid=1; last marks every bit of the final word in
// both directions.
module serial_master_port #(
    parameter int ADDR_DEPTH = 2000,
    parameter int SLAVES     = 3,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    parameter int TIMEOUT    = 64,
    localparam int ADDR_WIDTH = $clog2(ADDR_DEPTH),
    localparam int SLAVEID    = $clog2(SLAVES),
    localparam int LEN_W      = $clog2(MAX_BURST)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  req_rw,
    input  logic                  req_burst,
    input  logic [SLAVEID-1:0]    req_slave_id,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_W-1:0]      req_len,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  err_timeout,
    output logic                  control,
    output logic                  wD,
    output logic                  valid,
    output logic                  last,
    input  logic                  rD,
    input  logic                  ready,
    output logic [2:0]            state_dbg
);

    localparam int FRAME_W = 3 + SLAVEID + 2 + ADDR_WIDTH;
    localparam int CFG_CW  = $clog2(FRAME_W + 1);
    localparam int TO_CW   = $clog2(TIMEOUT + 1);
    localparam int BIT_CW  = $clog2(DATA_WIDTH) + 1;

    localparam logic [CFG_CW-1:0] CFG_DONE = CFG_CW'(FRAME_W);
    localparam logic [TO_CW-1:0]  TO_LAST  = TO_CW'(TIMEOUT - 1);
    localparam logic [BIT_CW-1:0] BIT_LAST = BIT_CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CONFIG   = 3'd1,
        S_WAIT_RDY = 3'd2,
        S_WRITE    = 3'd3,
        S_READ     = 3'd4
    } state_t;

    state_t                 state;
    logic                   rw_q;
    logic [LEN_W-1:0]       last_idx;   // index of the final word (0 for single)
    logic [FRAME_W-1:0]     frame_sr;
    logic [CFG_CW-1:0]      cfg_cnt;
    logic [TO_CW-1:0]       wait_cnt;
    logic                   seen_low;
    logic [BIT_CW-1:0]      bit_cnt;
    logic [LEN_W:0]         word_cnt;
    logic [DATA_WIDTH-1:0]  data_sr;    // remaining write bits, next one at MSB
    logic [DATA_WIDTH-2:0]  rd_sr;      // read bits collected so far in this word

    logic [FRAME_W-1:0]     frame_in;
    logic [LEN_W:0]         last_word;
    logic [LEN_W:0]         next_word;

    assign frame_in  = {3'b111, req_slave_id, req_rw, req_burst, req_addr};
    assign last_word = {1'b0, last_idx};
    assign next_word = word_cnt + 1'b1;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            rw_q        <= 1'b0;
            last_idx    <= '0;
            frame_sr    <= '0;
            cfg_cnt     <= '0;
            wait_cnt    <= '0;
            seen_low    <= 1'b0;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            data_sr     <= '0;
            rd_sr       <= '0;
            wr_pop      <= 1'b0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            control     <= 1'b0;
            wD          <= 1'b0;
            valid       <= 1'b0;
            last        <= 1'b0;
        end else begin
            // Single-cycle strobes
            wr_pop      <= 1'b0;
            rd_valid    <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (req) begin
                        rw_q     <= req_rw;
                        last_idx <= req_burst ? req_len : '0;
                        // First frame bit goes out now; the rest wait in frame_sr.
                        control  <= frame_in[FRAME_W-1];
                        frame_sr <= {frame_in[FRAME_W-2:0], 1'b0};
                        cfg_cnt  <= CFG_CW'(1);
                        busy     <= 1'b1;
                        state    <= S_CONFIG;
                    end
                end

                S_CONFIG: begin
                    if (cfg_cnt == CFG_DONE) begin
                        control  <= 1'b0;
                        wait_cnt <= '0;
                        seen_low <= 1'b0;
                        state    <= S_WAIT_RDY;
                    end else begin
                        control  <= frame_sr[FRAME_W-1];
                        frame_sr <= {frame_sr[FRAME_W-2:0], 1'b0};
                        cfg_cnt  <= cfg_cnt + 1'b1;
                    end
                end

                S_WAIT_RDY: begin
                    if (seen_low && ready) begin
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                        last     <= (last_idx == '0);
                        if (rw_q) begin
                            wD      <= wr_data[DATA_WIDTH-1];
                            data_sr <= {wr_data[DATA_WIDTH-2:0], 1'b0};
                            wr_pop  <= 1'b1;
                            valid   <= 1'b1;
                            state   <= S_WRITE;
                        end else begin
                            state   <= S_READ;
                        end
                    end else if (wait_cnt == TO_LAST) begin
                        done        <= 1'b1;
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (!ready) begin
                            seen_low <= 1'b1;
                        end
                    end
                end

                S_WRITE: begin
                    if (bit_cnt == BIT_LAST) begin
                        if (word_cnt == last_word) begin
                            wD    <= 1'b0;
                            valid <= 1'b0;
                            last  <= 1'b0;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            // Next word follows with no gap.
                            wD       <= wr_data[DATA_WIDTH-1];
                            data_sr  <= {wr_data[DATA_WIDTH-2:0], 1'b0};
                            wr_pop   <= 1'b1;
                            bit_cnt  <= '0;
                            word_cnt <= next_word;
                            last     <= (next_word == last_word);
                        end
                    end else begin
                        wD      <= data_sr[DATA_WIDTH-1];
                        data_sr <= {data_sr[DATA_WIDTH-2:0], 1'b0};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                S_READ: begin
                    rd_sr <= {rd_sr[DATA_WIDTH-3:0], rD};
                    if (bit_cnt == BIT_LAST) begin
                        rd_data  <= {rd_sr, rD};
                        rd_valid <= 1'b1;
                        bit_cnt  <= '0;
                        if (word_cnt == last_word) begin
                            last  <= 1'b0;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            word_cnt <= next_word;
                            last     <= (next_word == last_word);
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_master_port.sv
// Bench for serial_master_port with default parameters. Inputs are driven and
// outputs observed on the falling clock edge.
module tb_serial_master_port;

    localparam int DW = 32;
    localparam int FW = 18;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        req_rw = 1'b0;
    logic        req_burst = 1'b0;
    logic [1:0]  req_slave_id = '0;
    logic [10:0] req_addr = '0;
    logic [3:0]  req_len = '0;
    logic [31:0] wr_data = '0;
    logic        rD = 1'b0;
    logic        ready = 1'b1;
    logic        wr_pop, rd_valid, busy, done, err_timeout, control, wD, valid, last;
    logic [31:0] rd_data;
    logic [2:0]  state_dbg;

    serial_master_port dut (
        .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_burst(req_burst),
        .req_slave_id(req_slave_id), .req_addr(req_addr), .req_len(req_len),
        .wr_data(wr_data), .wr_pop(wr_pop), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .done(done), .err_timeout(err_timeout), .control(control),
        .wD(wD), .valid(valid), .last(last), .rD(rD), .ready(ready), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails = 0;
    int done_cnt = 0;
    int pop_idx = 0;
    logic [31:0]   tx_words[$];
    logic [DW-1:0] exp_q[$];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and do the per-cycle bookkeeping:
    // count done pulses, and hand the next write word out after each wr_pop.
    task automatic tick();
        @(negedge clk);
        if (done === 1'b1) done_cnt++;
        if (wr_pop === 1'b1) begin
            pop_idx++;
            wr_data = (pop_idx < tx_words.size()) ? tx_words[pop_idx] : $urandom();
        end
    endtask

    function automatic logic [FW-1:0] frame_of(input int id, input int rw, input int burst,
                                               input int addr);
        int f;
        f = 7 * (1 << 15) + id * (1 << 13) + rw * (1 << 12) + burst * (1 << 11) + addr;
        return FW'(f);
    endfunction

    task automatic send_frame(input int rw, input int burst, input int id, input int addr,
                              input int len, input bit spam, output logic [FW-1:0] got);
        got = '0;
        req_rw = rw[0]; req_burst = burst[0]; req_slave_id = id[1:0];
        req_addr = addr[10:0]; req_len = len[3:0]; req = 1'b1;
        tick();
        req = 1'b0;
        chk("busy_after_req", busy, 1);
        for (int i = 0; i < FW; i++) begin
            got = {got[FW-2:0], control};
            if (spam && i == 5) begin
                req = 1'b1; req_rw = ~req_rw; req_burst = ~req_burst;
                req_slave_id = 2'($urandom_range(0, 2));
                req_addr = 11'($urandom_range(0, 1999));
            end else begin
                req = 1'b0;
            end
            tick();
        end
        req = 1'b0;
        chk("frame", got, frame_of(id, rw, burst, addr));
        chk("control_zero_after_frame", control, 0);
    endtask

    task automatic handshake();
        ready = 1'b0;
        repeat ($urandom_range(1, 5)) tick();
        ready = 1'b1;
        tick();
    endtask

    task automatic do_write(input int id, input int addr, input int burst, input int len,
                            input bit spam, output logic [FW-1:0] fr);
        int n, base, lat, vcnt, lcnt, first_last, pops, pop_bad, busy_low;
        logic [31:0] w;
        n = burst ? len + 1 : 1;
        exp_q = tx_words;
        pop_idx = 0;
        wr_data = tx_words[0];
        base = done_cnt;
        send_frame(1, burst, id, addr, len, spam, fr);
        handshake();
        lat = 1;
        while (valid !== 1'b1 && lat < 8) begin tick(); lat++; end
        chk("write_start_latency", lat, 1);
        vcnt = 0; lcnt = 0; first_last = -1; pops = 0; pop_bad = 0; busy_low = 0; w = '0;
        for (int c = 0; c < n * DW; c++) begin
            w = {w[30:0], wD};
            if (valid === 1'b1) vcnt++;
            if (busy !== 1'b1) busy_low++;
            if (last === 1'b1) begin
                if (first_last < 0) first_last = c;
                lcnt++;
            end
            if (wr_pop === 1'b1) begin
                pops++;
                if (c % DW != 0) pop_bad++;
            end
            req = (spam && c == 40) ? 1'b1 : 1'b0;
            if (c % DW == DW - 1) chk("wD_word", w, exp_q.pop_front());
            tick();
        end
        req = 1'b0;
        chk("write_end_valid", valid, 0);
        chk("write_end_last", last, 0);
        chk("write_end_done", done, 1);
        chk("write_end_err", err_timeout, 0);
        chk("write_end_busy", busy, 0);
        chk("valid_cycles", vcnt, n * DW);
        chk("busy_low_midway", busy_low, 0);
        chk("last_cycles", lcnt, DW);
        chk("last_first_cycle", first_last, (n - 1) * DW);
        chk("wr_pop_count", pops, n);
        chk("wr_pop_misplaced", pop_bad, 0);
        repeat (3) tick();
        chk("write_done_count", done_cnt - base, 1);
        chk("write_idle_busy", busy, 0);
        chk("write_idle_control", control, 0);
    endtask

    task automatic do_read(input int id, input int addr, input int burst, input int len,
                           output logic [FW-1:0] fr);
        int n, base, rv, rv_bad, lcnt, first_last, busy_low;
        logic [31:0] cur;
        n = burst ? len + 1 : 1;
        exp_q = tx_words;
        base = done_cnt;
        send_frame(0, burst, id, addr, len, 1'b0, fr);
        handshake();
        rv = 0; rv_bad = 0; lcnt = 0; first_last = -1; busy_low = 0;
        for (int c = 0; c < n * DW; c++) begin
            cur = tx_words[c / DW];
            rD = cur[DW - 1 - (c % DW)];
            if (busy !== 1'b1) busy_low++;
            if (valid !== 1'b0) busy_low++;
            if (last === 1'b1) begin
                if (first_last < 0) first_last = c;
                lcnt++;
            end
            if (rd_valid === 1'b1) begin
                rv++;
                if (c == 0 || c % DW != 0) rv_bad++;
                else chk("rd_word", rd_data, exp_q.pop_front());
            end
            tick();
        end
        rD = 1'b0;
        chk("read_end_rd_valid", rd_valid, 1);
        chk("read_end_rd_data", rd_data, exp_q.pop_front());
        chk("read_end_done", done, 1);
        chk("read_end_last", last, 0);
        chk("read_end_busy", busy, 0);
        chk("read_mid_rd_valid", rv, n - 1);
        chk("read_rd_valid_misplaced", rv_bad, 0);
        chk("read_busy_or_valid_midway", busy_low, 0);
        chk("read_last_cycles", lcnt, DW);
        chk("read_last_first_cycle", first_last, (n - 1) * DW);
        tick();
        chk("rd_valid_one_cycle", rd_valid, 0);
        chk("read_done_count", done_cnt - base, 1);
    endtask

    initial begin
        logic [FW-1:0] fr;
        int early, vseen, base, rw, burst, len;

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        chk("reset_outputs", {wr_pop, rd_valid, busy, done, err_timeout, control, wD, valid, last}, 0);
        chk("reset_rd_data", rd_data, 0);
        reset = 1'b0;
        tick();

        // Single write, fixed fields
        tx_words = {32'hA5A5_0001};
        do_write(2, 5, 0, 0, 1'b0, fr);
        chk("frame_single_write", fr, 18'b1111010_00000000101);

        // Single read
        tx_words = {32'hDEADBEEF};
        do_read($urandom_range(0, 2), $urandom_range(0, 1999), 0, 0, fr);

        // Burst write of four words
        tx_words = {};
        repeat (4) tx_words.push_back($urandom());
        do_write($urandom_range(0, 2), $urandom_range(0, 1999), 1, 3, 1'b0, fr);
        chk("burst_frame_bit", fr[11], 1);

        // Timeout: ready never goes low
        base = done_cnt;
        send_frame($urandom_range(0, 1), 0, 1, 77, 0, 1'b0, fr);
        early = 0; vseen = 0;
        for (int j = 1; j < 64; j++) begin
            tick();
            if (done === 1'b1) early++;
            if (valid === 1'b1) vseen++;
        end
        tick();
        chk("timeout_done", done, 1);
        chk("timeout_err", err_timeout, 1);
        chk("timeout_busy", busy, 0);
        chk("timeout_early_done", early, 0);
        chk("timeout_valid_seen", vseen + int'(valid), 0);
        tick();
        chk("timeout_done_one_cycle", {done, err_timeout}, 0);
        chk("timeout_done_count", done_cnt - base, 1);

        // Reset during write bit 10, then a normal read
        tx_words = {$urandom()};
        pop_idx = 0;
        wr_data = tx_words[0];
        send_frame(1, 0, 0, 321, 0, 1'b0, fr);
        handshake();
        repeat (10) tick();
        chk("mid_write_valid", valid, 1);
        base = done_cnt;
        reset = 1'b1;
        tick();
        chk("abort_outputs", {wr_pop, rd_valid, busy, done, err_timeout, control, wD, valid, last}, 0);
        chk("abort_rd_data", rd_data, 0);
        reset = 1'b0;
        repeat (5) tick();
        chk("abort_no_done", done_cnt - base, 0);
        chk("abort_busy", busy, 0);
        tx_words = {$urandom()};
        do_read(1, 1999, 0, 0, fr);

        // req pulsed while busy is ignored
        tx_words = {};
        repeat (2) tx_words.push_back($urandom());
        do_write(2, 1234, 1, 1, 1'b1, fr);

        // Maximum burst both ways
        tx_words = {};
        repeat (16) tx_words.push_back($urandom());
        do_write($urandom_range(0, 2), $urandom_range(0, 1999), 1, 15, 1'b0, fr);
        tx_words = {};
        repeat (16) tx_words.push_back($urandom());
        do_read($urandom_range(0, 2), $urandom_range(0, 1999), 1, 15, fr);

        // Random transactions
        for (int t = 0; t < 6; t++) begin
            rw = $urandom_range(0, 1);
            burst = $urandom_range(0, 1);
            len = $urandom_range(0, 15);
            tx_words = {};
            repeat (burst ? len + 1 : 1) tx_words.push_back($urandom());
            if (rw == 1) do_write($urandom_range(0, 2), $urandom_range(0, 1999), burst, len, 1'b0, fr);
            else do_read($urandom_range(0, 2), $urandom_range(0, 1999), burst, len, fr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
